// File: rtl/message_sm_if.sv
// Message sequencer bus: game-logic triggers in,
// drawing requests and status out.
interface message_sm_if #(
  parameter int N_MSG = 4
);
  localparam int IW = (N_MSG > 1) ? $clog2(N_MSG) : 1;

  logic [N_MSG-1:0] trigger;
  logic             clear;
  logic [N_MSG-1:0] msg_DR;
  logic [IW-1:0]    msg_id;
  logic             busy;
  logic [N_MSG-1:0] pending;

  modport master (
    output trigger, clear,
    input  msg_DR, msg_id, busy, pending
  );

  modport slave (
    input  trigger, clear,
    output msg_DR, msg_id, busy, pending
  );
endinterface

// File: rtl/message_sm.sv
// Priority message sequencer: latches one-cycle events
// and shows one message at a time, timed or sticky.
module message_sm #(
  parameter int               N_MSG          = 4,
  parameter int               DISPLAY_CYCLES = 50_000_000,
  parameter logic [N_MSG-1:0] STICKY_MASK    = '0,
  parameter bit               PREEMPT        = 1'b1
) (
  input logic        clk,
  input logic        reset,
  message_sm_if.slave bus
);
  localparam int IW = (N_MSG > 1) ? $clog2(N_MSG) : 1;
  localparam int TW = $clog2(DISPLAY_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(DISPLAY_CYCLES - 1);

  typedef enum logic {S_IDLE, S_SHOW} state_t;

  state_t           state, stateN;
  logic [N_MSG-1:0] drQ, drN;
  logic [IW-1:0]    idQ, idN;
  logic             busyQ, busyN;
  logic [N_MSG-1:0] pendQ, pendN;
  logic [TW-1:0]    timer, timerN;

  logic [N_MSG-1:0] cand, newEv, hi;
  logic [IW-1:0]    pick;
  logic             curSticky;

  function automatic logic [IW-1:0] lowestIdx(
    input logic [N_MSG-1:0] v
  );
    lowestIdx = '0;
    for (int i = N_MSG - 1; i >= 0; i--)
      if (v[i]) lowestIdx = IW'(i);
  endfunction

  function automatic logic [N_MSG-1:0] oneHot(
    input logic [IW-1:0] k
  );
    oneHot = '0;
    for (int i = 0; i < N_MSG; i++)
      if (int'(k) == i) oneHot[i] = 1'b1;
  endfunction

  function automatic logic [N_MSG-1:0] lowerMask(
    input logic [IW-1:0] k
  );
    lowerMask = '0;
    for (int i = 0; i < N_MSG; i++)
      if (i < int'(k)) lowerMask[i] = 1'b1;
  endfunction

  assign bus.msg_DR  = drQ;
  assign bus.msg_id  = idQ;
  assign bus.busy    = busyQ;
  assign bus.pending = pendQ;

  // State and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      drQ   <= '0;
      idQ   <= '0;
      busyQ <= 1'b0;
      pendQ <= '0;
      timer <= '0;
    end else begin
      state <= stateN;
      drQ   <= drN;
      idQ   <= idN;
      busyQ <= busyN;
      pendQ <= pendN;
      timer <= timerN;
    end
  end

  // Selection, preemption, retrigger and timeout.
  always_comb begin
    stateN    = state;
    drN       = drQ;
    idN       = idQ;
    busyN     = busyQ;
    timerN    = timer;
    cand      = pendQ | bus.trigger;
    pendN     = cand;
    newEv     = pendQ | (bus.trigger & ~drQ);
    hi        = newEv & lowerMask(idQ);
    pick      = '0;
    curSticky = |(drQ & STICKY_MASK);
    unique case (state)
      S_IDLE: begin
        if (|cand) begin
          pick   = lowestIdx(cand);
          stateN = S_SHOW;
          drN    = oneHot(pick);
          idN    = pick;
          busyN  = 1'b1;
          timerN = '0;
          pendN  = cand & ~oneHot(pick);
        end
      end
      S_SHOW: begin
        if (bus.clear) begin
          stateN = S_IDLE;
          drN    = '0;
          idN    = '0;
          busyN  = 1'b0;
          timerN = '0;
          pendN  = cand;
        end else if (PREEMPT && |hi) begin
          pick   = lowestIdx(hi);
          drN    = oneHot(pick);
          idN    = pick;
          timerN = '0;
          pendN  = (newEv & ~oneHot(pick))
                 | (curSticky ? drQ : '0);
        end else begin
          pendN = newEv;
          if (|(bus.trigger & drQ)) begin
            timerN = '0;
          end else if (!curSticky) begin
            if (timer == TLAST) begin
              stateN = S_IDLE;
              drN    = '0;
              idN    = '0;
              busyN  = 1'b0;
              timerN = '0;
            end else begin
              timerN = timer + TW'(1);
            end
          end
        end
      end
    endcase
  end
endmodule

// File: tb/tb_message_sm.sv
// Directed bench for message_sm: vector table plus
// sticky-hold and asynchronous-reset sequences.
module tb_message_sm;
  logic clk;
  logic reset;

  message_sm_if #(.N_MSG(4)) bus();

  message_sm #(
    .N_MSG(4),
    .DISPLAY_CYCLES(5),
    .STICKY_MASK(4'b0001),
    .PREEMPT(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] trig;
    logic       clr;
    logic [3:0] dr;
    logic [1:0] id;
    logic [3:0] pend;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic add(input int n,
                     input logic [3:0] t,
                     input logic c,
                     input logic [3:0] d,
                     input logic [1:0] i,
                     input logic [3:0] p);
    vec_t v;
    v.trig = t; v.clr = c; v.dr = d; v.id = i; v.pend = p;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic chkAll(input string nm,
                        input logic [3:0] d,
                        input logic [1:0] i,
                        input logic [3:0] p);
    chk({nm, " dr"}, 32'(bus.msg_DR), 32'(d));
    chk({nm, " id"}, 32'(bus.msg_id), 32'(i));
    chk({nm, " busy"}, 32'(bus.busy), 32'(|d));
    chk({nm, " pend"}, 32'(bus.pending), 32'(p));
  endtask

  task automatic step(input logic [3:0] t, input logic c);
    bus.trigger = t;
    bus.clear   = c;
    @(posedge clk);
    #1;
    bus.trigger = '0;
    bus.clear   = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    bus.trigger = '0;
    bus.clear   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chkAll("reset", 4'b0000, 2'd0, 4'b0000);
    reset = 1'b0;

    // basic timeout on channel 2
    add(5, 4'b0000, 0, 4'b0000, 0, 4'b0000);
    vecs.delete();
    add(1, 4'b0100, 0, 4'b0100, 2, 4'b0000);
    add(4, 4'b0000, 0, 4'b0100, 2, 4'b0000);
    add(2, 4'b0000, 0, 4'b0000, 0, 4'b0000);
    // priority and queuing
    add(1, 4'b1010, 0, 4'b0010, 1, 4'b1000);
    add(4, 4'b0000, 0, 4'b0010, 1, 4'b1000);
    add(1, 4'b0000, 0, 4'b0000, 0, 4'b1000);
    add(5, 4'b0000, 0, 4'b1000, 3, 4'b0000);
    add(1, 4'b0000, 0, 4'b0000, 0, 4'b0000);
    // preemption of non-sticky 2 by sticky 0
    add(1, 4'b0100, 0, 4'b0100, 2, 4'b0000);
    add(1, 4'b0000, 0, 4'b0100, 2, 4'b0000);
    add(1, 4'b0001, 0, 4'b0001, 0, 4'b0000);
    add(1, 4'b0001, 0, 4'b0001, 0, 4'b0000);
    add(1, 4'b0000, 1, 4'b0000, 0, 4'b0000);
    // retrigger in cycle 3: 8 cycles visible
    add(1, 4'b1000, 0, 4'b1000, 3, 4'b0000);
    add(2, 4'b0000, 0, 4'b1000, 3, 4'b0000);
    add(1, 4'b1000, 0, 4'b1000, 3, 4'b0000);
    add(4, 4'b0000, 0, 4'b1000, 3, 4'b0000);
    add(1, 4'b0000, 0, 4'b0000, 0, 4'b0000);
    // clear together with own trigger
    add(1, 4'b1000, 0, 4'b1000, 3, 4'b0000);
    add(1, 4'b1000, 1, 4'b0000, 0, 4'b1000);
    add(5, 4'b0000, 0, 4'b1000, 3, 4'b0000);
    add(1, 4'b0000, 0, 4'b0000, 0, 4'b0000);
    // preemption on the timeout edge
    add(5, 4'b0000, 0, 4'b0000, 0, 4'b0000);
    vecs.pop_back(); vecs.pop_back(); vecs.pop_back();
    vecs.pop_back(); vecs.pop_back();
    add(1, 4'b0100, 0, 4'b0100, 2, 4'b0000);
    add(4, 4'b0000, 0, 4'b0100, 2, 4'b0000);
    add(1, 4'b0010, 0, 4'b0010, 1, 4'b0000);
    add(4, 4'b0000, 0, 4'b0010, 1, 4'b0000);
    add(1, 4'b0000, 0, 4'b0000, 0, 4'b0000);
    // lower-priority accumulate and merge
    add(1, 4'b0010, 0, 4'b0010, 1, 4'b0000);
    add(2, 4'b0100, 0, 4'b0010, 1, 4'b0100);
    add(2, 4'b0000, 0, 4'b0010, 1, 4'b0100);
    add(1, 4'b0000, 0, 4'b0000, 0, 4'b0100);
    add(5, 4'b0000, 0, 4'b0100, 2, 4'b0000);
    add(1, 4'b0000, 0, 4'b0000, 0, 4'b0000);
    // clear while idle is ignored
    add(1, 4'b0000, 1, 4'b0000, 0, 4'b0000);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].trig, vecs[i].clr);
      chkAll($sformatf("row%0d", i),
             vecs[i].dr, vecs[i].id, vecs[i].pend);
    end

    // sticky game over held 100 cycles
    step(4'b0001, 1'b0);
    chkAll("sticky on", 4'b0001, 2'd0, 4'b0000);
    for (int i = 0; i < 100; i++) begin
      step(4'b0000, 1'b0);
      chk($sformatf("sticky hold%0d", i),
          32'(bus.msg_DR), 32'h1);
    end
    step(4'b0000, 1'b1);
    chkAll("sticky clr", 4'b0000, 2'd0, 4'b0000);

    // asynchronous reset between edges
    step(4'b1010, 1'b0);
    step(4'b0000, 1'b0);
    chkAll("pre rst", 4'b0010, 2'd1, 4'b1000);
    #2;
    reset = 1'b1;
    #1;
    chkAll("async rst", 4'b0000, 2'd0, 4'b0000);
    #2;
    reset = 1'b0;
    step(4'b0100, 1'b0);
    chkAll("post rst", 4'b0100, 2'd2, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
